// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the 4:1 select, with a registered, qualified data output.
// Optional grant hold limit enabled by defining ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter #(
  parameter int unsigned DW       = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    winner;
  logic          found;
  logic          rel;
  logic          live;
  logic [DW-1:0] dout_q, din_sel;
  logic          dout_vld_q;

  // First set request bit scanning upward from the rotating pointer.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && req[ptr_q + 2'(i)]) begin
        winner = ptr_q + 2'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    din_sel = din0;
    unique case (sel_q)
      2'd0: din_sel = din0;
      2'd1: din_sel = din1;
      2'd2: din_sel = din2;
      2'd3: din_sel = din3;
      default: din_sel = din0;
    endcase
  end

  assign live = gnt_q[sel_q] & req[sel_q];

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [CW-1:0] hold_q, hold_d;
  logic          hold_at_max;
  logic          others;

  assign hold_at_max = (hold_q == CW'(MAX_HOLD - 1));
  assign others      = |(req & ~(4'b0001 << sel_q));
  // Forced release only when someone else is waiting; otherwise the count saturates.
  assign rel         = !req[sel_q] || (hold_at_max && others);

  always_comb begin
    hold_d = hold_q;
    if (state_q == StIdle) begin
      if (found) hold_d = '0;
    end else if (!rel && !hold_at_max) begin
      hold_d = hold_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign rel             = !req[sel_q];
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
        end
      end
      StGrant: begin
        if (rel) begin
          state_d = StIdle;
          gnt_d   = 4'b0000;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      ptr_q      <= 2'd0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      dout_vld_q <= live;
      if (live) dout_q <= din_sel;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign busy     = (state_q == StGrant);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios then randomized traffic,
// all compared against an integer-level arbitration model.
module tb_mux4_rr_arbiter;
  localparam int unsigned DW       = 1;
  localparam int unsigned MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] din [4];
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          busy;

  mux4_rr_arbiter #(
    .DW       (DW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .din0     (din[0]),
    .din1     (din[1]),
    .din2     (din[2]),
    .din3     (din[3]),
    .gnt      (gnt),
    .sel      (sel),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: granted index (-1 when none), rotating start index, hold count.
  int            m_gnt, m_sel, m_ptr, m_hold;
  logic [DW-1:0] m_dout;
  logic          m_vld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt  = -1;
    m_sel  = 0;
    m_ptr  = 0;
    m_hold = 0;
    m_dout = '0;
    m_vld  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [3:0] r;
    int         first;
    r = req;
    m_vld = (m_gnt >= 0) && r[m_sel];
    if (m_vld) m_dout = din[m_sel];
    if (m_gnt < 0) begin
      if (r != 4'b0000) begin
        first = -1;
        for (int k = 0; k < 4; k++)
          if (first < 0 && r[(m_ptr + k) % 4]) first = (m_ptr + k) % 4;
        m_gnt  = first;
        m_sel  = first;
        m_hold = 0;
      end
    end else if (!r[m_gnt]) begin
      m_ptr = (m_gnt + 1) % 4;
      m_gnt = -1;
    end
`ifdef ARB_HOLD_LIMIT_EN
    else if (m_hold == MAX_HOLD - 1 && (r & ~(4'b0001 << m_gnt)) != 4'b0000) begin
      m_ptr = (m_gnt + 1) % 4;
      m_gnt = -1;
    end else if (m_hold < MAX_HOLD - 1) begin
      m_hold++;
    end
`endif
  endtask

  task automatic check_outputs();
    logic [3:0] exp_gnt;
    exp_gnt = (m_gnt < 0) ? 4'b0000 : (4'b0001 << m_gnt);
    check("gnt", gnt, exp_gnt);
    check("sel", sel, m_sel);
    check("dout", dout, m_dout);
    check("dout_vld", dout_vld, m_vld);
    check("busy", busy, m_gnt >= 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    int   order [5] = '{0, 1, 2, 3, 0};
    logic pat [4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   run, first_g1;
    bit   run_done;

    rst_n = 1'b0;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) din[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    rst_n = 1'b1;

    // Fairness: every requester drops two cycles after its grant, re-raises one later.
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("fair_sel", sel, order[n]);
      tick();
      req[order[n]] = 1'b0;
      tick();
      check("fair_gap", gnt, 4'b0000);
      req[order[n]] = 1'b1;
    end
    req = 4'b0000;
    tick();

    // Single requester with a data pattern on din2.
    req = 4'b0100;
    tick();
    check("single_sel", sel, 2);
    for (int i = 0; i < 4; i++) begin
      din[2] = pat[i];
      tick();
      check("single_dout", dout, pat[i]);
      check("single_vld", dout_vld, 1'b1);
    end
    req = 4'b0000;
    tick();
    tick();
    check("single_busy", busy, 1'b0);

    // Rotation past an idle requester: release of 1 with 1001 pending goes to 3.
    req = 4'b0010;
    tick();
    check("rot_first", sel, 1);
    req = 4'b1001;
    tick();
    tick();
    check("rot_sel", sel, 3);

    // Asynchronous reset mid-grant, then arbitration restarts at pointer 0.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #1 rst_n = 1'b1;
    req = 4'b1010;
    tick();
    check("post_reset_sel", sel, 1);

    // Hold-limit scenario: req[0] held, req[1] raised in cycle 2, req[0] drops in cycle 20.
    req = 4'b0000;
    tick();
    tick();
    req      = 4'b0001;
    run      = 0;
    run_done = 1'b0;
    first_g1 = -1;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (!run_done) begin
        if (gnt === 4'b0001) run++;
        else if (run > 0) run_done = 1'b1;
      end
      if (first_g1 < 0 && gnt === 4'b0010) first_g1 = c;
      if (c == 2) req[1] = 1'b1;
      if (c == 20) req[0] = 1'b0;
    end
`ifdef ARB_HOLD_LIMIT_EN
    check("hold_run", run, 4);
    check("hold_next", first_g1, 6);
`else
    check("hold_run", run, 20);
    check("hold_next", first_g1, 22);
`endif

    // Randomized traffic: requests change on roughly a quarter of the cycles.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) din[i] = DW'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
